ps2_key_ctl: RTL
================

// Module: ps2_key_ctl
// PURPOSE
//  PS/2 keyboard receiver and key-state decoder feeding the ship position controller.
//  - Deserialises PS/2 device-to-host frames.
//  - Tracks make/break codes for three game keys.
//  - Drives level-valid left/right/fire held flags, synchronous to pclk.
//  - The ship controller consumes left/right directly; fire goes to the bullet logic.
// PARAMETERS
//  KEY_LEFT        8'h6B   scan code for left (arrow with E0 prefix, or keypad 4)
//  KEY_RIGHT       8'h74   scan code for right (arrow with E0 prefix, or keypad 6)
//  KEY_FIRE        8'h29   scan code for fire (space)
//  TIMEOUT_CYCLES  65000   pclk cycles without a ps2_clk falling edge before a partial frame is aborted
// PORTS
//  pclk       in   1  system clock
//  rst        in   1  reset, synchronous, active-high
//  ps2_clk    in   1  raw PS/2 clock from the pad, asynchronous
//  ps2_data   in   1  raw PS/2 data from the pad, asynchronous
//  left       out  1  1 while KEY_LEFT is held
//  right      out  1  1 while KEY_RIGHT is held
//  fire       out  1  1 while KEY_FIRE is held
//  frame_err  out  1  one-cycle pulse on a bad start, parity, stop or timeout
// BEHAVIOUR
//  Input sampling
//  - ps2_clk and ps2_data each pass through a 2-FF synchroniser.
//  - fall = synced clk previous 1, current 0. All frame sampling uses synced data in the fall cycle.
//  Receive FSM: IDLE, DATA, PARITY, STOP.
//  - IDLE:   on fall with data=0 -> DATA, bit_cnt=0.
//            On fall with data=1 (bad start) -> stay IDLE, pulse frame_err.
//  - DATA:   on each fall, shift data in LSB-first. After the 8th bit -> PARITY.
//  - PARITY: on fall, latch the bit -> STOP.
//  - STOP:   on fall -> IDLE.
//            If stop=1 and (^byte ^ parity)==1 (odd parity), pulse byte_valid next cycle.
//            Otherwise pulse frame_err and discard the byte.
//  Watchdog
//  - 17-bit counter cleared on every fall and while in IDLE; increments otherwise.
//  - At TIMEOUT_CYCLES in a non-IDLE state: -> IDLE, pulse frame_err, counter cleared, partial byte dropped.
//  Decoder, acting on byte_valid
//  - 8'hF0: set brk_pend.
//  - 8'hE0: set ext_pend. The prefix is accepted and otherwise ignored; key matching does not depend on it.
//  - Any other byte:
//    - Matching key flag <= ~brk_pend.
//    - Then clear brk_pend and ext_pend.
//    - Unmatched codes change no key flag, but still clear both pending flags.
//  - Repeated make codes (typematic) leave the flag at 1.
//  Key outputs
//  - Registered and independent; left and right may both be 1. Downstream resolves priority.
//  Latency
//  - Stop bit sampled in fall cycle N -> byte_valid at N+1 -> left/right/fire updated at N+2.
//  - frame_err is asserted at N+1 for a stop/parity error.
//  - frame_err is asserted at N+1 for a bad start bit, where N is the start-bit fall cycle.
//  Reset
//  - left=0, right=0, fire=0, frame_err=0.
//  - FSM=IDLE, bit_cnt=0, brk_pend=0, ext_pend=0, watchdog=0, shift reg=0.
//  - Synchroniser flops reset to 1 (idle bus level).
//  - Reset mid-frame discards the partial frame.
//  - The next frame is received only from its own start bit.
//  Width rules
//  - bit_cnt is 3 bits and wraps after bit 7 into PARITY.
//  - No arithmetic on scan codes; compares are exact 8-bit equality.
// TESTING
//  1. Frame 0x6B (parity=0, stop=1) -> left=1 two cycles after the stop fall; right=0, fire=0.
//  2. E0 6B, then E0 F0 6B -> left rises after the first 6B; left falls after the final 6B; frame_err never pulses.
//  3. Frame 0x29 with parity=1 (bad) -> frame_err pulses for 1 cycle; fire stays 0; brk_pend unchanged.
//  4. Send 4 bits of a frame, then hold ps2_clk high for TIMEOUT_CYCLES -> frame_err pulse, FSM back to IDLE.
//     Then a full 0x74 frame -> right=1.
//  5. Press 6B then 74 (both held) -> left=1 and right=1 together. F0 74 -> right=0, left stays 1.
//  6. Assert rst at bit 5 of a 0x29 frame, release, send a full 0x29 frame -> fire=0 through reset.
//     fire=1 only after the clean frame.

Source files
------------

// File: rtl/ps2_key_ctl.sv
// PS/2 keyboard receiver with make/break decoding for the left, right and fire game keys.
// Key flags are level outputs; frame_err pulses once per rejected or abandoned frame.
module ps2_key_ctl #(
  parameter logic [7:0] KEY_LEFT       = 8'h6B,
  parameter logic [7:0] KEY_RIGHT      = 8'h74,
  parameter logic [7:0] KEY_FIRE       = 8'h29,
  parameter int         TIMEOUT_CYCLES = 65000
) (
  input  logic pclk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic left,
  output logic right,
  output logic fire,
  output logic frame_err
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam logic [16:0] TIMEOUT_VAL = 17'(TIMEOUT_CYCLES);
  localparam logic [7:0]  CODE_BREAK  = 8'hF0;
  localparam logic [7:0]  CODE_EXT    = 8'hE0;

  state_t      state;
  state_t      state_next;
  logic        clk_s1;
  logic        clk_s2;
  logic        clk_d;
  logic        data_s1;
  logic        data_s2;
  logic        fall;
  logic        timeout;
  logic        frame_ok;
  logic        frame_bad;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        par_bit;
  logic [16:0] wdog;
  logic        byte_valid;
  logic [7:0]  rx_byte;
  logic        brk_pend;
  logic        ext_pend;

  // Synchronisers idle high so reset never manufactures a falling edge.
  always_ff @(posedge pclk) begin
    if (rst) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      clk_d   <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      clk_d   <= clk_s2;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
    end
  end

  assign fall    = clk_d & ~clk_s2;
  assign timeout = (state != IDLE) && !fall && (wdog == TIMEOUT_VAL);

  always_ff @(posedge pclk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (timeout) begin
      state_next = IDLE;
    end else if (fall) begin
      case (state)
        IDLE:    state_next = data_s2 ? IDLE : DATA;
        DATA:    state_next = (bit_cnt == 3'd7) ? PARITY : DATA;
        PARITY:  state_next = STOP;
        STOP:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end else begin
      state_next = state;
    end
  end

  always_comb begin
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    if (timeout) begin
      frame_bad = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE: frame_bad = data_s2;
        STOP: begin
          // Odd parity: data plus parity bit must hold an odd number of ones.
          if (data_s2 && ((^shift) ^ par_bit)) frame_ok = 1'b1;
          else                                  frame_bad = 1'b1;
        end
        default: frame_ok = 1'b0;
      endcase
    end else begin
      frame_ok = 1'b0;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      bit_cnt    <= 3'd0;
      shift      <= 8'h00;
      par_bit    <= 1'b0;
      wdog       <= 17'd0;
      byte_valid <= 1'b0;
      rx_byte    <= 8'h00;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= frame_ok;
      frame_err  <= frame_bad;
      if (frame_ok) rx_byte <= shift;
      if (fall || timeout || state == IDLE) wdog <= 17'd0;
      else                                  wdog <= wdog + 17'd1;
      if (timeout) begin
        bit_cnt <= 3'd0;
        shift   <= 8'h00;
      end else if (fall) begin
        case (state)
          IDLE: begin
            bit_cnt <= 3'd0;
            shift   <= 8'h00;
          end
          DATA: begin
            shift   <= {data_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY:  par_bit <= data_s2;
          default: bit_cnt <= bit_cnt;
        endcase
      end
    end
  end

  // Prefix bytes arm pending flags; any other byte resolves them.
  always_ff @(posedge pclk) begin
    if (rst) begin
      left     <= 1'b0;
      right    <= 1'b0;
      fire     <= 1'b0;
      brk_pend <= 1'b0;
      ext_pend <= 1'b0;
    end else if (byte_valid) begin
      if (rx_byte == CODE_BREAK) begin
        brk_pend <= 1'b1;
        ext_pend <= ext_pend;
      end else if (rx_byte == CODE_EXT) begin
        ext_pend <= 1'b1;
      end else begin
        if (rx_byte == KEY_LEFT)  left  <= ~brk_pend;
        if (rx_byte == KEY_RIGHT) right <= ~brk_pend;
        if (rx_byte == KEY_FIRE)  fire  <= ~brk_pend;
        brk_pend <= 1'b0;
        ext_pend <= 1'b0;
      end
    end
  end

endmodule
